// File: rtl/rx_burst.sv
// rx_burst: receive-side burst framer ahead of the GMSK demodulator.
// Waits (while armed) for QUALIFY_SAMPLES consecutive hot I/Q samples, then
// forwards one burst of BURST_SYMBOLS*SAMPLES_PER_SYMBOL samples, starting at
// the first hot sample, with symbol strobes and a symbol index attached.
// Optional feature macro: RX_BURST_ABORT_EN enables the loss-of-signal abort
// (DROP_SAMPLES consecutive cold samples end the capture early).
module rx_burst #(
   parameter int SAMPLE_BITS        = 8,
   parameter int SAMPLES_PER_SYMBOL = 4,
   parameter int BURST_SYMBOLS      = 148,
   parameter int THRESHOLD          = 32,
   parameter int QUALIFY_SAMPLES    = 4,
   parameter int DROP_SAMPLES       = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          arm,
   output logic                          is_armed,
   input  logic signed [SAMPLE_BITS-1:0] rfchain_inphase,
   input  logic signed [SAMPLE_BITS-1:0] rfchain_quadrature,
   input  logic                          iq_valid,
   output logic signed [SAMPLE_BITS-1:0] demod_inphase,
   output logic signed [SAMPLE_BITS-1:0] demod_quadrature,
   output logic                          demod_valid,
   output logic                          symbol_strobe,
   output logic [7:0]                    symbol_index,
   output logic                          burst_done,
   output logic                          burst_aborted
);

   localparam int MAG_W    = SAMPLE_BITS + 1;
   localparam int PAIR_W   = 2 * SAMPLE_BITS;
   localparam int LOG2SPS  = $clog2(SAMPLES_PER_SYMBOL);
   localparam int TOTAL    = BURST_SYMBOLS * SAMPLES_PER_SYMBOL;
   localparam int CNT_W    = $clog2(TOTAL);
   localparam int STREAK_W = $clog2(QUALIFY_SAMPLES);
   localparam int DL_LEN   = QUALIFY_SAMPLES - 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] SPS_MASK = CNT_W'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(QUALIFY_SAMPLES - 1);
`ifdef RX_BURST_ABORT_EN
   localparam int DROP_W = $clog2(DROP_SAMPLES);
   localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_SAMPLES - 1);
`endif

   typedef enum logic [1:0] {IDLE, ARMED, QUALIFY, CAPTURE} state_t;

   // Two's-complement magnitude widened by one bit so that the most negative
   // sample maps to a positive value without wrapping.
   function automatic logic [MAG_W-1:0] absVal(input logic signed [SAMPLE_BITS-1:0] v);
      logic [MAG_W-1:0] ext;
      ext = {v[SAMPLE_BITS-1], v};
      return v[SAMPLE_BITS-1] ? (~ext + MAG_W'(1)) : ext;
   endfunction

   state_t                state_q, state_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic [CNT_W-1:0]      sampleCnt_q, sampleCnt_d;
   logic                  pendValid_q, pendValid_d;
   logic                  pendDone_q, pendDone_d;
   logic [PAIR_W-1:0]     pendData_q, pendData_d;
   logic [CNT_W-1:0]      pendIndex_q, pendIndex_d;
   logic [PAIR_W-1:0]     delay_q [DL_LEN];
   logic                  isArmed_q, demodValid_q, strobe_q, done_q;
   logic [PAIR_W-1:0]     demodData_q;
   logic [7:0]            symIndex_q;
`ifdef RX_BURST_ABORT_EN
   logic [DROP_W-1:0]     dropCnt_q, dropCnt_d;
   logic                  pendAbort_q, pendAbort_d;
   logic                  aborted_q;
`endif

   logic [MAG_W-1:0]  mag;
   logic              hot;
   logic              validHot;
   logic [PAIR_W-1:0] tail;

   assign mag      = absVal(rfchain_inphase) + absVal(rfchain_quadrature);
   assign hot      = (mag >= MAG_W'(THRESHOLD));
   assign validHot = iq_valid && hot;
   assign tail     = delay_q[DL_LEN-1];

   // Delay line of accepted samples; its tail lags the input by exactly the
   // qualification length so the burst starts at the first hot sample.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DL_LEN; k++) delay_q[k] <= '0;
      end else if (iq_valid) begin
         delay_q[0] <= {rfchain_inphase, rfchain_quadrature};
         for (int k = 1; k < DL_LEN; k++) delay_q[k] <= delay_q[k-1];
      end
   end

   // Framing state, qualification streak, burst sample counter and the
   // pending-emission stage that feeds the registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         sampleCnt_q <= '0;
         pendValid_q <= 1'b0;
         pendDone_q  <= 1'b0;
         pendData_q  <= '0;
         pendIndex_q <= '0;
`ifdef RX_BURST_ABORT_EN
         dropCnt_q   <= '0;
         pendAbort_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         sampleCnt_q <= sampleCnt_d;
         pendValid_q <= pendValid_d;
         pendDone_q  <= pendDone_d;
         pendData_q  <= pendData_d;
         pendIndex_q <= pendIndex_d;
`ifdef RX_BURST_ABORT_EN
         dropCnt_q   <= dropCnt_d;
         pendAbort_q <= pendAbort_d;
`endif
      end
   end

   // Next-state logic: arming, streak qualification, and per-sample emission
   // with completion taking priority over a simultaneous loss of signal.
   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      sampleCnt_d = sampleCnt_q;
      pendValid_d = 1'b0;
      pendDone_d  = 1'b0;
      pendData_d  = pendData_q;
      pendIndex_d = pendIndex_q;
`ifdef RX_BURST_ABORT_EN
      dropCnt_d   = dropCnt_q;
      pendAbort_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (arm) state_d = ARMED;
         end
         ARMED: begin
            if (validHot) begin
               state_d  = QUALIFY;
               streak_d = STREAK_W'(1);
            end
         end
         QUALIFY: begin
            if (iq_valid) begin
               if (!hot) begin
                  state_d  = ARMED;
                  streak_d = '0;
               end else if (streak_q == STREAK_LAST) begin
                  state_d     = CAPTURE;
                  streak_d    = '0;
                  pendValid_d = 1'b1;
                  pendData_d  = tail;
                  pendIndex_d = '0;
                  sampleCnt_d = CNT_W'(1);
`ifdef RX_BURST_ABORT_EN
                  dropCnt_d   = '0;
`endif
               end else begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end
         end
         CAPTURE: begin
            if (iq_valid) begin
               pendValid_d = 1'b1;
               pendData_d  = tail;
               pendIndex_d = sampleCnt_q;
               sampleCnt_d = sampleCnt_q + CNT_W'(1);
               if (sampleCnt_q == LAST_CNT) begin
                  pendDone_d  = 1'b1;
                  state_d     = IDLE;
                  sampleCnt_d = '0;
               end
`ifdef RX_BURST_ABORT_EN
               else if (!hot && (dropCnt_q == DROP_LAST)) begin
                  pendValid_d = 1'b0;
                  pendAbort_d = 1'b1;
                  state_d     = IDLE;
                  sampleCnt_d = '0;
                  dropCnt_d   = '0;
               end else begin
                  dropCnt_d = hot ? '0 : (dropCnt_q + DROP_W'(1));
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs; sample data and symbol index hold between pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         isArmed_q    <= 1'b0;
         demodValid_q <= 1'b0;
         strobe_q     <= 1'b0;
         done_q       <= 1'b0;
         demodData_q  <= '0;
         symIndex_q   <= '0;
`ifdef RX_BURST_ABORT_EN
         aborted_q    <= 1'b0;
`endif
      end else begin
         isArmed_q    <= (state_q == ARMED) || (state_q == QUALIFY);
         demodValid_q <= pendValid_q;
         strobe_q     <= pendValid_q && ((pendIndex_q & SPS_MASK) == '0);
         done_q       <= pendDone_q;
         if (pendValid_q) begin
            demodData_q <= pendData_q;
            symIndex_q  <= 8'(pendIndex_q >> LOG2SPS);
         end
`ifdef RX_BURST_ABORT_EN
         aborted_q    <= pendAbort_q;
`endif
      end
   end

   assign is_armed         = isArmed_q;
   assign demod_valid      = demodValid_q;
   assign symbol_strobe    = strobe_q;
   assign symbol_index     = symIndex_q;
   assign burst_done       = done_q;
   assign demod_inphase    = demodData_q[PAIR_W-1:SAMPLE_BITS];
   assign demod_quadrature = demodData_q[SAMPLE_BITS-1:0];
`ifdef RX_BURST_ABORT_EN
   assign burst_aborted    = aborted_q;
`else
   assign burst_aborted    = 1'b0;
`endif

endmodule

// File: tb/tb_rx_burst.sv
// tb_rx_burst: self-checking bench for rx_burst. Random I/Q streams are fed
// and the forwarded burst is compared with a queue-based reference model
// that applies the framing rules directly to the list of accepted samples.
`timescale 1ns/1ps
module tb_rx_burst;

   localparam int QUAL  = 4;
   localparam int SPS   = 4;
   localparam int SYMS  = 148;
   localparam int THR   = 32;
   localparam int DROP  = 16;
   localparam int TOTAL = SYMS * SPS;
`ifdef RX_BURST_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              arm = 1'b0;
   logic              iq_valid = 1'b0;
   logic signed [7:0] rfchain_inphase = '0;
   logic signed [7:0] rfchain_quadrature = '0;
   logic              is_armed;
   logic signed [7:0] demod_inphase;
   logic signed [7:0] demod_quadrature;
   logic              demod_valid;
   logic              symbol_strobe;
   logic [7:0]        symbol_index;
   logic              burst_done;
   logic              burst_aborted;

   typedef struct { int i; int q; int edgeNo; } fed_t;
   typedef struct { int i; int q; int strobe; int index; int done; int edgeNo; } out_t;

   fed_t fedQ[$];
   out_t outQ[$];
   bit   armedAt[int];
   int   edgeCnt = 0;
   int   checks = 0;
   int   failures = 0;
   int   strobeCount = 0;
   int   doneCount = 0;
   int   abortCount = 0;
   int   lastAbortEdge = 0;
   int   holdErrors = 0;
   bit   haveLast = 1'b0;
   logic signed [7:0] lastI = '0;
   logic signed [7:0] lastQ = '0;

   rx_burst dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .arm                (arm),
      .is_armed           (is_armed),
      .rfchain_inphase    (rfchain_inphase),
      .rfchain_quadrature (rfchain_quadrature),
      .iq_valid           (iq_valid),
      .demod_inphase      (demod_inphase),
      .demod_quadrature   (demod_quadrature),
      .demod_valid        (demod_valid),
      .symbol_strobe      (symbol_strobe),
      .symbol_index       (symbol_index),
      .burst_done         (burst_done),
      .burst_aborted      (burst_aborted)
   );

   // Free-running clock with a 10 ns period.
   always #5 clock = ~clock;

   // Number each rising edge so acceptance and output timing can be compared.
   always @(posedge clock) edgeCnt <= edgeCnt + 1;

   // Record every forwarded sample and pulse shortly after each rising edge.
   always @(posedge clock) begin
      out_t o;
      #2;
      armedAt[edgeCnt] = is_armed;
      if (demod_valid) begin
         o.i = int'(demod_inphase);
         o.q = int'(demod_quadrature);
         o.strobe = int'(symbol_strobe);
         o.index = int'(symbol_index);
         o.done = int'(burst_done);
         o.edgeNo = edgeCnt;
         outQ.push_back(o);
         lastI = demod_inphase;
         lastQ = demod_quadrature;
         haveLast = 1'b1;
      end else if (haveLast && (demod_inphase !== lastI || demod_quadrature !== lastQ)) begin
         holdErrors++;
      end
      if (symbol_strobe) strobeCount++;
      if (burst_done) doneCount++;
      if (burst_aborted) begin
         abortCount++;
         lastAbortEdge = edgeCnt;
      end
   end

   function automatic bit isHot(input int i, input int q);
      int m;
      m = (i < 0 ? -i : i) + (q < 0 ? -q : q);
      return m >= THR;
   endfunction

   task automatic checkOutput(input string tag, input logic signed [31:0] observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock of stimulus, applied at the falling edge.
   task automatic applyStimulus(input bit a, input bit v, input int i, input int q);
      fed_t f;
      arm = a;
      iq_valid = v;
      rfchain_inphase = 8'(i);
      rfchain_quadrature = 8'(q);
      if (v) begin
         f.i = i;
         f.q = q;
         f.edgeNo = edgeCnt + 1;
         fedQ.push_back(f);
      end
      @(negedge clock);
   endtask

   task automatic randHot(output int i, output int q);
      i = int'($urandom_range(127, 32));
      if ($urandom_range(1, 0) == 1) i = -i;
      q = int'($urandom_range(40, 0)) - 20;
   endtask

   task automatic randCold(output int i, output int q);
      i = int'($urandom_range(30, 0)) - 15;
      q = int'($urandom_range(30, 0)) - 15;
   endtask

   task automatic feedHot(input int n, input bit a);
      int i, q;
      for (int k = 0; k < n; k++) begin
         randHot(i, q);
         applyStimulus(a, 1'b1, i, q);
      end
   endtask

   task automatic feedCold(input int n);
      int i, q;
      for (int k = 0; k < n; k++) begin
         randCold(i, q);
         applyStimulus(1'b0, 1'b1, i, q);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0);
   endtask

   task automatic clearMonitor();
      outQ.delete();
      fedQ.delete();
      strobeCount = 0;
      doneCount = 0;
      abortCount = 0;
      holdErrors = 0;
      haveLast = 1'b0;
   endtask

   task automatic armBlock();
      applyStimulus(1'b1, 1'b0, 0, 0);
      clearMonitor();
   endtask

   // Reference model: locate the first run of QUAL hot samples, then forward
   // samples from its start, one per later acceptance, until the burst length
   // is reached or (when enabled) DROP consecutive cold samples arrive.
   task automatic verifyBurst(input string tag);
      out_t expQ[$];
      out_t e;
      int   start, streak, coldRun, expStrobes, expDone, n, a, expAbortEdge;
      bit   expAbort;
      start = -1; streak = 0; coldRun = 0; expStrobes = 0; expDone = 0;
      expAbort = 1'b0; expAbortEdge = 0;
      for (int j = 0; j < fedQ.size(); j++) begin
         if (isHot(fedQ[j].i, fedQ[j].q)) streak++;
         else streak = 0;
         if (streak == QUAL) begin
            start = j - QUAL + 1;
            break;
         end
      end
      if (start >= 0) begin
         for (int p = 0; p < TOTAL; p++) begin
            a = start + QUAL - 1 + p;
            if (a >= fedQ.size()) break;
            if (p > 0 && ABORT_EN) begin
               coldRun = isHot(fedQ[a].i, fedQ[a].q) ? 0 : coldRun + 1;
               if (coldRun == DROP && p != TOTAL - 1) begin
                  expAbort = 1'b1;
                  expAbortEdge = fedQ[a].edgeNo + 1;
                  break;
               end
            end
            e.i = fedQ[start + p].i;
            e.q = fedQ[start + p].q;
            e.strobe = (p % SPS == 0) ? 1 : 0;
            e.index = p / SPS;
            e.done = (p == TOTAL - 1) ? 1 : 0;
            e.edgeNo = fedQ[a].edgeNo + 1;
            expStrobes += e.strobe;
            expDone += e.done;
            expQ.push_back(e);
         end
      end
      checkOutput({tag, "_count"}, outQ.size(), expQ.size());
      n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
      for (int k = 0; k < n; k++) begin
         checkOutput($sformatf("%s_i[%0d]", tag, k), outQ[k].i, expQ[k].i);
         checkOutput($sformatf("%s_q[%0d]", tag, k), outQ[k].q, expQ[k].q);
         checkOutput($sformatf("%s_strobe[%0d]", tag, k), outQ[k].strobe, expQ[k].strobe);
         checkOutput($sformatf("%s_index[%0d]", tag, k), outQ[k].index, expQ[k].index);
         checkOutput($sformatf("%s_done[%0d]", tag, k), outQ[k].done, expQ[k].done);
         checkOutput($sformatf("%s_edge[%0d]", tag, k), outQ[k].edgeNo, expQ[k].edgeNo);
      end
      checkOutput({tag, "_strobe_pulses"}, strobeCount, expStrobes);
      checkOutput({tag, "_done_pulses"}, doneCount, expDone);
      checkOutput({tag, "_abort_pulses"}, abortCount, int'(expAbort));
      if (expAbort) checkOutput({tag, "_abort_edge"}, lastAbortEdge, expAbortEdge);
      checkOutput({tag, "_data_hold"}, holdErrors, 0);
   endtask

   // Directed sequence of randomized scenarios.
   initial begin
      int firstEdge;
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset_demod_valid", demod_valid, 0);
      checkOutput("reset_is_armed", is_armed, 0);
      checkOutput("reset_strobe", symbol_strobe, 0);
      checkOutput("reset_index", symbol_index, 0);
      checkOutput("reset_done", burst_done, 0);
      checkOutput("reset_aborted", burst_aborted, 0);
      checkOutput("reset_demod_i", demod_inphase, 0);
      checkOutput("reset_demod_q", demod_quadrature, 0);
      reset_n = 1'b1;
      idle(2);
      checkOutput("idle_is_armed", is_armed, 0);

      $display("[TB] full capture");
      armBlock();
      applyStimulus(1'b0, 1'b1, 5, 5);
      checkOutput("armed_after_arm", is_armed, 1);
      for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 5, 5);
      applyStimulus(1'b0, 1'b1, 40, 0);
      feedHot(599, 1'b0);
      idle(4);
      verifyBurst("full");
      if (outQ.size() > 0) begin
         firstEdge = outQ[0].edgeNo;
         checkOutput("full_first_i", outQ[0].i, 40);
         checkOutput("full_armed_before_first", armedAt[firstEdge - 1], 1);
         checkOutput("full_disarmed_at_first", armedAt[firstEdge], 0);
      end

      clearMonitor();
      feedHot(20, 1'b0);
      idle(2);
      checkOutput("no_capture_without_arm", outQ.size(), 0);
      checkOutput("idle_after_done", is_armed, 0);

      $display("[TB] streak break and magnitude boundaries");
      armBlock();
      feedHot(3, 1'b1);
      applyStimulus(1'b1, 1'b1, -16, 15);
      applyStimulus(1'b1, 1'b1, -128, 0);
      applyStimulus(1'b1, 1'b1, 20, 12);
      feedHot(52, 1'b1);
      feedHot(560, 1'b0);
      idle(4);
      verifyBurst("streak");
      if (outQ.size() > 1) begin
         firstEdge = outQ[0].edgeNo;
         checkOutput("neg128_first_i", outQ[0].i, -128);
         checkOutput("mag32_second_q", outQ[1].q, 12);
         checkOutput("streak_armed_before_first", armedAt[firstEdge - 1], 1);
         checkOutput("streak_disarmed_at_first", armedAt[firstEdge], 0);
      end

      $display("[TB] gapped input");
      armBlock();
      for (int k = 0; k < 1300; k++) begin
         int i, q;
         randHot(i, q);
         applyStimulus(1'b0, (k % 2) == 0, i, q);
      end
      idle(4);
      verifyBurst("gapped");

      $display("[TB] random mix");
      armBlock();
      for (int k = 0; k < 1500; k++) begin
         int i, q;
         if ($urandom_range(9, 0) < 9) randHot(i, q);
         else randCold(i, q);
         applyStimulus(1'b0, $urandom_range(9, 0) < 7, i, q);
      end
      idle(4);
      verifyBurst("random");

      $display("[TB] loss of signal");
      armBlock();
      feedHot(103, 1'b0);
      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 0, 0);
      feedHot(500, 1'b0);
      idle(4);
      verifyBurst("drop");
`ifdef RX_BURST_ABORT_EN
      checkOutput("drop_emitted", outQ.size(), 115);
`else
      checkOutput("drop_emitted", outQ.size(), 592);
`endif

      $display("[TB] cold tail coinciding with completion");
      armBlock();
      feedHot(579, 1'b0);
      feedCold(16);
      applyStimulus(1'b1, 1'b0, 0, 0);
      idle(4);
      verifyBurst("coincide");

      $display("[TB] reset mid-burst");
      clearMonitor();
      checkOutput("rearmed_back_to_back", is_armed, 1);
      feedHot(200, 1'b0);
      idle(1);
      checkOutput("pre_reset_index", symbol_index, 49);
      clearMonitor();
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", demod_valid, 0);
      checkOutput("async_reset_i", demod_inphase, 0);
      checkOutput("async_reset_q", demod_quadrature, 0);
      checkOutput("async_reset_index", symbol_index, 0);
      checkOutput("async_reset_strobe", symbol_strobe, 0);
      idle(3);
      reset_n = 1'b1;
      idle(3);
      checkOutput("reset_no_done", doneCount, 0);
      checkOutput("reset_no_abort", abortCount, 0);
      checkOutput("reset_no_output", outQ.size(), 0);
      checkOutput("reset_is_armed_cleared", is_armed, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_burst.md
# rx_burst

Receive-side burst framer: the counterpart of the GMSK transmit burst feeder. It accepts signed I/Q samples from the RF chain, waits while armed for sustained signal energy, and then forwards exactly one burst's worth of samples to the GMSK demodulator. Its outputs carry symbol-boundary strobes and a symbol index, so the demodulator needs no framing logic of its own.

## Interface
- SAMPLE_BITS, 8, signed I/Q width (ROM_OUTPUT_BITS+1).
- SAMPLES_PER_SYMBOL, 4, oversampling ratio; must be a power of two.
- BURST_SYMBOLS, 148, symbols per burst.
- THRESHOLD, 32, energy threshold on |I|+|Q| (SAMPLE_BITS+1 bits, unsigned).
- QUALIFY_SAMPLES, 4, consecutive above-threshold samples required to declare a burst (≥2).
- DROP_SAMPLES, 16, consecutive below-threshold samples that abort a capture.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  request to arm; honoured only in IDLE.
- is_armed  out  1  high in ARMED and QUALIFY.
- rfchain_inphase  in  SAMPLE_BITS  signed I sample.
- rfchain_quadrature  in  SAMPLE_BITS  signed Q sample.
- iq_valid  in  1  I/Q inputs valid this cycle.
- demod_inphase  out  SAMPLE_BITS  forwarded I sample.
- demod_quadrature  out  SAMPLE_BITS  forwarded Q sample.
- demod_valid  out  1  forwarded sample valid (one-cycle pulse per sample).
- symbol_strobe  out  1  with demod_valid on the first sample of each symbol.
- symbol_index  out  8  symbol number of the current demod sample, 0..BURST_SYMBOLS-1.
- burst_done  out  1  one-cycle pulse coincident with the last demod_valid.
- burst_aborted  out  1  one-cycle pulse on loss of signal.

## Operation
- Magnitude: mag = |I|+|Q|, computed in SAMPLE_BITS+1 bits, unsigned. |−128| = 128, so there is no overflow. A sample is "hot" when mag ≥ THRESHOLD.
- Delay line: QUALIFY_SAMPLES-1 entries of {I,Q}. It shifts on every iq_valid in every state.
- FSM states:
  - IDLE: arm=1 → ARMED.
  - ARMED: a hot valid sample → QUALIFY with streak=1.
  - QUALIFY: a hot valid sample increments streak. A cold valid sample → ARMED with streak cleared. Cycles with iq_valid=0 neither extend nor break the streak. When streak reaches QUALIFY_SAMPLES → CAPTURE.
  - CAPTURE: on every valid sample, emit the delay-line tail, i.e. the sample accepted QUALIFY_SAMPLES-1 valid samples earlier. The first emitted sample is the first hot sample.
- Sample counter: counts 0..BURST_SYMBOLS·SAMPLES_PER_SYMBOL−1.
  - symbol_strobe is asserted when the counter's low log2(SAMPLES_PER_SYMBOL) bits are 0.
  - symbol_index = counter >> log2(SAMPLES_PER_SYMBOL).
- Completion: after the last sample, pulse burst_done and return to IDLE. The block must be re-armed before it captures again.
- Abort: in CAPTURE, count consecutive cold valid samples. A hot sample clears the count. When the count reaches DROP_SAMPLES:
  - pulse burst_aborted, without demod_valid on that cycle;
  - return to IDLE.
- Abort and final sample on the same cycle: burst_done wins and burst_aborted stays low.
- arm is ignored outside IDLE.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; counters 0; delay line 0.
- arm sampled high in IDLE → is_armed=1 on the next edge.
- Qualification: the QUALIFY_SAMPLES-th hot sample is accepted at edge N. At edge N+1:
  - demod_valid=1 with the first hot sample;
  - symbol_strobe=1, symbol_index=0;
  - is_armed=0.
- Capture: each subsequent iq_valid at edge M → demod outputs at edge M+1. Cycles with iq_valid=0 produce demod_valid=0, and demod data holds its value.
- demod_valid, symbol_strobe, burst_done and burst_aborted are single-cycle pulses.
- demod_inphase and demod_quadrature hold their last value between pulses.
- Reset asserted mid-capture: outputs clear immediately (asynchronously); no burst_done or burst_aborted pulse.
- Back-to-back bursts: re-arming is possible on the cycle after burst_done.

## Configuration
- RX_BURST_ABORT_EN:
  - Defined: loss-of-signal abort logic and burst_aborted as specified above.
  - Undefined: no drop counter; burst_aborted is tied to 0; a capture always runs the full BURST_SYMBOLS·SAMPLES_PER_SYMBOL samples.

## Test plan
- Full capture (defaults): reset, arm, feed 10 cold samples (I=Q=5), then 600 hot samples (I=40, Q=0) on every cycle.
  - Expect exactly 592 demod_valid pulses, the first carrying the first hot sample.
  - Expect 148 symbol_strobe pulses, symbol_index 0..147, and burst_done on the 592nd pulse.
- Streak break: arm, feed 3 hot samples, 1 cold, then 4 hot → capture starts with the first of the final 4 hot samples; is_armed stays 1 until then.
- Gapped input: iq_valid toggling 1,0 with hot samples → demod_valid follows each valid sample by one cycle; qualification takes exactly 4 valid samples.
- Abort (RX_BURST_ABORT_EN defined): capture 100 hot samples, then 16 cold (I=Q=0) → burst_aborted pulses on the 16th cold sample, state returns to IDLE, and there are no further demod_valid pulses.
- Abort coinciding with completion: set DROP_SAMPLES=16 and make samples 577–592 cold → burst_done=1 and burst_aborted=0.
- Boundaries: I=−128, Q=0 gives mag 128 (hot); THRESHOLD=32 with |I|+|Q|=31 is cold. arm held high during CAPTURE has no effect. Asserting reset_n=0 mid-burst clears all outputs immediately.
